// File: rtl/enemy_missile_ctl_pkg.sv
// Shared constants, FSM encoding and LFSR step for the enemy missile controller.
package enemy_missile_ctl_pkg;
  localparam int unsigned N_SLOTS = 5;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned LFSR_W  = 16;

  localparam logic [COORD_W-1:0] PARK_X = '0;
  localparam logic [COORD_W-1:0] PARK_Y = '0;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Zero-based tap indices for polynomial taps 16,14,13,11.
  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 13;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 10;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_PICK   = 2'd1,
    ST_LAUNCH = 2'd2
  } fire_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction
endpackage

// File: rtl/enemy_missile_slot.sv
// One missile slot: load from the launcher, fall on each step, park when retired or cleared.
module enemy_missile_slot
  import enemy_missile_ctl_pkg::*;
#(
  parameter int unsigned STEP_PX  = 4,
  parameter int unsigned Y_BOTTOM = 768
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               step,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               clear,
  output logic               active,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);
  localparam int unsigned YW = COORD_W + 1;

  // One extra bit so the bottom compare cannot wrap.
  logic [YW-1:0] y_step;
  assign y_step = {1'b0, y} + YW'(STEP_PX);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      x      <= PARK_X;
      y      <= PARK_Y;
    end else if (clear) begin
      active <= 1'b0;
      x      <= PARK_X;
      y      <= PARK_Y;
    end else if (load) begin
      active <= 1'b1;
      x      <= load_x;
      y      <= load_y;
    end else if (step && active) begin
      if (y_step >= YW'(Y_BOTTOM)) begin
        active <= 1'b0;
        x      <= PARK_X;
        y      <= PARK_Y;
      end else begin
        y <= y_step[COORD_W-1:0];
      end
    end
  end
endmodule

// File: rtl/enemy_missile_ctl.sv
// Enemy missile producer: step timer, LFSR column pick, launch FSM and a pool of five slots.
module enemy_missile_ctl
  import enemy_missile_ctl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 250000,
  parameter int unsigned STEP_PX     = 4,
  parameter int unsigned FIRE_PERIOD = 40,
  parameter int unsigned Y_BOTTOM    = 768,
  parameter int unsigned COL_PITCH   = 64,
  parameter int unsigned X_OFF       = 24,
  parameter int unsigned Y_OFF       = 32
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               enable,
  input  logic [COORD_W-1:0] form_x,
  input  logic [COORD_W-1:0] form_y,
  input  logic [7:0]         alive_mask,
  input  logic               ship_hit,
  output logic [COORD_W-1:0] en_x_missile1,
  output logic [COORD_W-1:0] en_x_missile2,
  output logic [COORD_W-1:0] en_x_missile3,
  output logic [COORD_W-1:0] en_x_missile4,
  output logic [COORD_W-1:0] en_x_missile5,
  output logic [COORD_W-1:0] en_y_missile1,
  output logic [COORD_W-1:0] en_y_missile2,
  output logic [COORD_W-1:0] en_y_missile3,
  output logic [COORD_W-1:0] en_y_missile4,
  output logic [COORD_W-1:0] en_y_missile5,
  output logic [N_SLOTS-1:0] active,
  output logic               launch
);
  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned FC_W  = $clog2(FIRE_PERIOD + 1);

  logic [CNT_W-1:0]   step_cnt;
  logic               step;
  logic [LFSR_W-1:0]  lfsr;
  logic [FC_W-1:0]    fire_cnt;
  logic [2:0]         col;
  logic [2:0]         tries;
  fire_state_e        state, state_nxt;
  logic [N_SLOTS-1:0] slot_active;
  logic [N_SLOTS-1:0] load_sel;
  logic               any_idle, fire_due, pick_ok, do_load, pick_next;
  logic [COORD_W-1:0] launch_x, launch_y;
  logic [COORD_W-1:0] slot_x [N_SLOTS];
  logic [COORD_W-1:0] slot_y [N_SLOTS];

  // Movement step timer.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)       step_cnt <= '0;
    else if (step) step_cnt <= '0;
    else           step_cnt <= step_cnt + CNT_W'(1);
  end
  assign step = (step_cnt == CNT_W'(STEP_CYCLES - 1));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  assign any_idle = ~&slot_active;
  assign pick_ok  = alive_mask[col] && any_idle;
  assign fire_due = (state == ST_WAIT) && step && enable && (fire_cnt == FC_W'(1));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ship_hit) begin
      state_nxt = ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:   if (fire_due) state_nxt = ST_PICK;
        ST_PICK: begin
          if (pick_ok)                          state_nxt = ST_LAUNCH;
          else if (!any_idle || tries == 3'd7)  state_nxt = ST_WAIT;
        end
        ST_LAUNCH: state_nxt = ST_WAIT;
        default:   state_nxt = ST_WAIT;
      endcase
    end
  end

  // The slot is loaded as PICK succeeds so it is visible during the LAUNCH cycle.
  always_comb begin
    do_load   = 1'b0;
    pick_next = 1'b0;
    if (!ship_hit && state == ST_PICK) begin
      do_load   = pick_ok;
      pick_next = !pick_ok && any_idle && (tries != 3'd7);
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fire_cnt <= FC_W'(FIRE_PERIOD);
      col      <= '0;
      tries    <= '0;
      launch   <= 1'b0;
    end else begin
      launch <= do_load;
      if (!ship_hit && state == ST_WAIT) begin
        if (!enable) begin
          fire_cnt <= FC_W'(FIRE_PERIOD);
        end else if (step) begin
          if (fire_cnt == FC_W'(1)) begin
            fire_cnt <= FC_W'(FIRE_PERIOD);
            col      <= lfsr[2:0];
            tries    <= '0;
          end else begin
            fire_cnt <= fire_cnt - FC_W'(1);
          end
        end
      end
      if (pick_next) begin
        col   <= col + 3'd1;
        tries <= tries + 3'd1;
      end
    end
  end

  // Lowest-index idle slot wins.
  always_comb begin
    load_sel = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        load_sel    = '0;
        load_sel[i] = do_load;
      end
    end
  end

  assign launch_x = COORD_W'(32'(form_x) + 32'(col) * COL_PITCH + X_OFF);
  assign launch_y = COORD_W'(32'(form_y) + Y_OFF);

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    enemy_missile_slot #(
      .STEP_PX  (STEP_PX),
      .Y_BOTTOM (Y_BOTTOM)
    ) u_slot (
      .pclk   (pclk),
      .rst    (rst),
      .step   (step),
      .load   (load_sel[k]),
      .load_x (launch_x),
      .load_y (launch_y),
      .clear  (ship_hit),
      .active (slot_active[k]),
      .x      (slot_x[k]),
      .y      (slot_y[k])
    );
  end

  assign active        = slot_active;
  assign en_x_missile1 = slot_x[0];
  assign en_x_missile2 = slot_x[1];
  assign en_x_missile3 = slot_x[2];
  assign en_x_missile4 = slot_x[3];
  assign en_x_missile5 = slot_x[4];
  assign en_y_missile1 = slot_y[0];
  assign en_y_missile2 = slot_y[1];
  assign en_y_missile3 = slot_y[2];
  assign en_y_missile4 = slot_y[3];
  assign en_y_missile5 = slot_y[4];
endmodule

// File: tb/tb_enemy_missile_ctl.sv
// Directed bench for enemy_missile_ctl with hand-computed timing and coordinates.
module tb_enemy_missile_ctl;
  logic        pclk = 1'b0;
  logic        rst;
  logic        enable;
  logic [10:0] form_x, form_y;
  logic [7:0]  alive_mask;
  logic        ship_hit;
  logic [10:0] ex1, ex2, ex3, ex4, ex5;
  logic [10:0] ey1, ey2, ey3, ey4, ey5;
  logic [4:0]  active;
  logic        launch;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int n;
  bit found;

  always #5 pclk = ~pclk;

  enemy_missile_ctl #(
    .STEP_CYCLES (4),
    .STEP_PX     (4),
    .FIRE_PERIOD (2),
    .Y_BOTTOM    (200),
    .COL_PITCH   (64),
    .X_OFF       (24),
    .Y_OFF       (32)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .enable        (enable),
    .form_x        (form_x),
    .form_y        (form_y),
    .alive_mask    (alive_mask),
    .ship_hit      (ship_hit),
    .en_x_missile1 (ex1),
    .en_x_missile2 (ex2),
    .en_x_missile3 (ex3),
    .en_x_missile4 (ex4),
    .en_x_missile5 (ex5),
    .en_y_missile1 (ey1),
    .en_y_missile2 (ey2),
    .en_y_missile3 (ey3),
    .en_y_missile4 (ey4),
    .en_y_missile5 (ey5),
    .active        (active),
    .launch        (launch)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic wait_launch(input int max_cyc, output bit hit, output int cyc);
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < max_cyc) begin
      tick();
      cyc++;
      if (launch) hit = 1'b1;
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    check("async_rst_active", int'(active), 0);
    check("async_rst_launch", int'(launch), 0);
    check("async_rst_x1", int'(ex1), 0);
    check("async_rst_y1", int'(ey1), 0);
    @(posedge pclk);
    #1 rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; form_x = 11'd100; form_y = 11'd50;
    alive_mask = 8'hFF; ship_hit = 1'b0;
    // Pin the column seed to 3 so launch columns and PICK counts are known.
    force dut.lfsr = 16'h0003;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_active", int'(active), 0);
    check("rst_launch", int'(launch), 0);
    check("rst_x1", int'(ex1), 0);
    check("rst_y5", int'(ey5), 0);
    rst = 1'b0;
    edge_n = 0;

    // First launch: two steps then PICK and LAUNCH, column 3.
    wait_launch(20, found, n);
    check("first_found", int'(found), 1);
    check("first_lat", n, 9);
    check("first_x1", int'(ex1), 316);
    check("first_y1", int'(ey1), 82);
    check("first_active", int'(active), 1);
    tick();
    check("launch_pulse_end", int'(launch), 0);
    tick_to(12);
    check("move_y1", int'(ey1), 86);
    check("move_x1", int'(ex1), 316);

    // Reset mid-flight, then the same latency again.
    do_reset();
    wait_launch(20, found, n);
    check("rerst_lat", n, 9);
    check("rerst_active", int'(active), 1);

    // Slot 2 launched low so it retires first; fill the pool.
    form_y = 11'd124;
    wait_launch(20, found, n);
    check("l2_lat", n, 8);
    check("l2_y2", int'(ey2), 156);
    form_y = 11'd50;
    for (int i = 0; i < 3; i++) begin
      wait_launch(20, found, n);
      check($sformatf("l%0d_lat", i + 3), n, 8);
    end
    check("full_active", int'(active), 31);
    check("full_x5", int'(ex5), 316);
    check("full_y1", int'(ey1), 114);
    check("full_y5", int'(ey5), 82);
    wait_launch(16, found, n);
    check("full_nolaunch", int'(found), 0);
    check("full_y1_moves", int'(ey1), 130);
    check("full_y5_moves", int'(ey5), 98);
    check("y2_below_bottom", int'(ey2), 196);
    check("full_active2", int'(active), 31);
    tick_to(60);
    check("retire_active", int'(active), 29);
    check("retire_x2", int'(ex2), 0);
    check("retire_y2", int'(ey2), 0);
    wait_launch(20, found, n);
    check("refill_lat", n, 5);
    check("refill_active", int'(active), 31);
    check("refill_x2", int'(ex2), 316);
    check("refill_y2", int'(ey2), 82);
    check("refill_y3", int'(ey3), 122);

    // Dead-column skip: 3 picks to reach column 5, 8 picks to reach column 2.
    alive_mask = 8'b0010_0000;
    do_reset();
    wait_launch(20, found, n);
    check("skip5_lat", n, 11);
    check("skip5_x1", int'(ex1), 444);
    check("skip5_y1", int'(ey1), 82);
    alive_mask = 8'b0000_0100;
    wait_launch(30, found, n);
    check("skip2_lat", n, 17);
    check("skip2_x2", int'(ex2), 252);
    alive_mask = 8'h00;
    wait_launch(16, found, n);
    check("dead_nolaunch", int'(found), 0);
    alive_mask = 8'hFF;
    wait_launch(20, found, n);
    check("after_abandon_lat", n, 9);
    check("after_abandon_x3", int'(ex3), 316);
    check("after_abandon_active", int'(active), 7);

    // ship_hit during the commit cycle and during the LAUNCH cycle.
    do_reset();
    wait_launch(20, found, n);
    check("hit_pre_lat", n, 9);
    tick_to(16);
    ship_hit = 1'b1;
    tick();
    ship_hit = 1'b0;
    check("hit_pick_active", int'(active), 0);
    check("hit_pick_launch", int'(launch), 0);
    check("hit_pick_x1", int'(ex1), 0);
    check("hit_pick_y1", int'(ey1), 0);
    wait_launch(20, found, n);
    check("hit_next_lat", n, 8);
    wait_launch(20, found, n);
    check("hit_l2_lat", n, 8);
    check("hit_l2_active", int'(active), 3);
    ship_hit = 1'b1;
    tick();
    ship_hit = 1'b0;
    check("hit_launch_active", int'(active), 0);
    check("hit_launch_pulse", int'(launch), 0);
    check("hit_launch_x2", int'(ex2), 0);
    check("hit_launch_y2", int'(ey2), 0);
    wait_launch(20, found, n);
    check("hit_after_lat", n, 7);

    // enable low for 10 steps: no launches, flying missile keeps falling.
    enable = 1'b0;
    wait_launch(40, found, n);
    check("dis_nolaunch", int'(found), 0);
    check("dis_active", int'(active), 1);
    check("dis_y1", int'(ey1), 122);
    enable = 1'b1;
    wait_launch(20, found, n);
    check("en_lat", n, 8);
    check("en_active", int'(active), 3);
    check("en_x2", int'(ex2), 316);

    release dut.lfsr;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
